// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline.
//
// Arbitrates three hazard sources in fixed priority:
//   1. data-memory wait (freeze the whole front end, bubble MEM/WB)
//   2. taken branch resolved in MEM (redirect PC, flush IF/ID, ID/EX, EX/MEM)
//   3. load-use (hold PC and IF/ID, bubble ID/EX)
// Control outputs are combinational from the current state and inputs.
// State, the wait counter, the performance counters and the timeout flag are registered.
//
// Ports:
//   clk_i, rst_i                        clock, synchronous active-high reset
//   idex_memread_i, idex_rd_i           load in EX and its destination register
//   ifid_rs1_i, ifid_rs2_i              source registers of the instruction in ID
//   exmem_branch_i, exmem_zero_i        branch resolution in MEM
//   mem_req_i, mem_ready_i              data-memory access request / completion
//   pc_write_o, pc_src_o                PC enable and branch-target select
//   ifid_write_o, ifid_flush_o          IF/ID enable and NOP load
//   idex_bubble_o                       ID/EX control zeroing
//   exmem_write_o, exmem_bubble_o       EX/MEM enable and control zeroing
//   memwb_bubble_o                      MEM/WB control zeroing
//   busy_o                              waiting on data memory
//   stall_cnt_o, flush_cnt_o            cycles with PC held / taken-branch flushes
//   err_timeout_o                       sticky memory-timeout flag
module pipeline_hazard_ctrl #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             idex_memread_i,
  input  logic [4:0]       idex_rd_i,
  input  logic [4:0]       ifid_rs1_i,
  input  logic [4:0]       ifid_rs2_i,
  input  logic             exmem_branch_i,
  input  logic             exmem_zero_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             ifid_write_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             exmem_write_o,
  output logic             exmem_bubble_o,
  output logic             memwb_bubble_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic             err_timeout_o
);

  localparam int unsigned WcntW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WcntW-1:0] WcntMax = WcntW'(MEM_TIMEOUT);

  typedef enum logic [0:0] {StRun, StMemWait} state_e;

  state_e           state_q, state_d;
  logic [WcntW-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             err_q, err_d;

  logic mem_stall;
  logic br_taken;
  logic load_use;
  logic freeze;
  logic flush_taken;

  assign mem_stall = mem_req_i & ~mem_ready_i;
  assign br_taken  = exmem_branch_i & exmem_zero_i;
  assign load_use  = idex_memread_i & (idex_rd_i != 5'd0) &
                     ((idex_rd_i == ifid_rs1_i) | (idex_rd_i == ifid_rs2_i));

  // Once waiting, the freeze holds until ready even if mem_req_i drops.
  assign freeze = mem_stall | ((state_q == StMemWait) & ~mem_ready_i);

  // Control outputs
  always_comb begin
    pc_write_o     = 1'b1;
    pc_src_o       = 1'b0;
    ifid_write_o   = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_write_o  = 1'b1;
    exmem_bubble_o = 1'b0;
    memwb_bubble_o = 1'b0;
    flush_taken    = 1'b0;
    if (!rst_i) begin
      if (freeze) begin
        // EX/MEM and ID/EX are frozen, so branch and load-use wait for release.
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        exmem_write_o  = 1'b0;
        memwb_bubble_o = 1'b1;
      end else if (br_taken) begin
        // A coincident load-use is dropped: its instruction is flushed anyway.
        pc_src_o       = 1'b1;
        ifid_flush_o   = 1'b1;
        idex_bubble_o  = 1'b1;
        exmem_bubble_o = 1'b1;
        flush_taken    = 1'b1;
      end else if (load_use) begin
        pc_write_o     = 1'b0;
        ifid_write_o   = 1'b0;
        idex_bubble_o  = 1'b1;
      end
    end
  end

  // Next-state, wait counter, perf counters and timeout flag
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    err_d       = err_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;

    unique case (state_q)
      StRun: begin
        if (mem_stall) begin
          state_d = StMemWait;
          wcnt_d  = WcntW'(1);
        end
      end
      StMemWait: begin
        if (mem_ready_i) begin
          state_d = StRun;
          wcnt_d  = '0;
        end else begin
          if (wcnt_q == WcntMax) begin
            err_d = 1'b1;
          end else begin
            wcnt_d = wcnt_q + WcntW'(1);
          end
        end
      end
      default: begin
        state_d = StRun;
        wcnt_d  = '0;
      end
    endcase

    if (!pc_write_o) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_taken) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StRun;
      wcnt_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      err_q       <= err_d;
    end
  end

  assign busy_o        = (state_q == StMemWait);
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;
  assign err_timeout_o = err_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl. The driver applies one directed vector per
// cycle just after the rising edge and queues the hand-computed response for that cycle;
// the monitor pops and compares on the falling edge. Counter/flag expectations are the
// registered values visible during that cycle (i.e. the result of earlier cycles).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CntW = 8;
  localparam int unsigned Tmo  = 4;

  // {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_write, exmem_bubble,
  //  memwb_bubble}
  localparam logic [7:0] Def = 8'b1010_0100;
  localparam logic [7:0] Frz = 8'b0000_0001;
  localparam logic [7:0] Brt = 8'b1111_1110;
  localparam logic [7:0] Lu  = 8'b0000_1100;

  logic            clk;
  logic            rst;
  logic            idex_memread;
  logic [4:0]      idex_rd, ifid_rs1, ifid_rs2;
  logic            exmem_branch, exmem_zero, mem_req, mem_ready;
  logic            pc_write, pc_src, ifid_write, ifid_flush, idex_bubble;
  logic            exmem_write, exmem_bubble, memwb_bubble, busy, err_timeout;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(
    .CNT_W       (CntW),
    .MEM_TIMEOUT (Tmo)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .idex_memread_i (idex_memread),
    .idex_rd_i      (idex_rd),
    .ifid_rs1_i     (ifid_rs1),
    .ifid_rs2_i     (ifid_rs2),
    .exmem_branch_i (exmem_branch),
    .exmem_zero_i   (exmem_zero),
    .mem_req_i      (mem_req),
    .mem_ready_i    (mem_ready),
    .pc_write_o     (pc_write),
    .pc_src_o       (pc_src),
    .ifid_write_o   (ifid_write),
    .ifid_flush_o   (ifid_flush),
    .idex_bubble_o  (idex_bubble),
    .exmem_write_o  (exmem_write),
    .exmem_bubble_o (exmem_bubble),
    .memwb_bubble_o (memwb_bubble),
    .busy_o         (busy),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt),
    .err_timeout_o  (err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]      ctrl;
    logic            busy;
    logic [CntW-1:0] stall;
    logic [CntW-1:0] flush;
    logic            err;
    string           name;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Monitor: compare whatever response is pending for this cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t            e;
      logic [7:0]      act_ctrl;
      e        = exp_q.pop_front();
      act_ctrl = {pc_write, pc_src, ifid_write, ifid_flush, idex_bubble, exmem_write,
                  exmem_bubble, memwb_bubble};
      checks++;
      if (act_ctrl !== e.ctrl || busy !== e.busy || stall_cnt !== e.stall ||
          flush_cnt !== e.flush || err_timeout !== e.err) begin
        errors++;
        $display("FAIL %s: got ctrl=%b busy=%b stall=%0d flush=%0d err=%b, expected ctrl=%b busy=%b stall=%0d flush=%0d err=%b",
                 e.name, act_ctrl, busy, stall_cnt, flush_cnt, err_timeout,
                 e.ctrl, e.busy, e.stall, e.flush, e.err);
      end
    end
  end

  // Apply one cycle of inputs, queue its expected response, advance to the next cycle.
  task automatic step(input logic r, input logic mr, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                      input logic zr, input logic rq, input logic rdy,
                      input logic [7:0] ectrl, input logic ebusy, input int estall,
                      input int eflush, input logic eerr, input string name);
    exp_t e;
    rst          = r;
    idex_memread = mr;
    idex_rd      = rd;
    ifid_rs1     = rs1;
    ifid_rs2     = rs2;
    exmem_branch = br;
    exmem_zero   = zr;
    mem_req      = rq;
    mem_ready    = rdy;
    e.ctrl  = ectrl;
    e.busy  = ebusy;
    e.stall = CntW'(estall);
    e.flush = CntW'(eflush);
    e.err   = eerr;
    e.name  = name;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    rst = 1'b1; idex_memread = 1'b0; idex_rd = '0; ifid_rs1 = '0; ifid_rs2 = '0;
    exmem_branch = 1'b0; exmem_zero = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    // First edge with rst high clears all state.
    @(posedge clk);
    #1;
    //   rst mr rd rs1 rs2 br zr rq rdy  ctrl busy stall flush err
    step(1, 1, 5, 5, 0, 1, 1, 1, 0, Def, 0, 0, 0, 0, "rst_forces_default");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0, 0, 0, "idle");
    step(0, 1, 5, 5, 0, 0, 0, 0, 0, Lu,  0, 0, 0, 0, "load_use_rs1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 1, 0, 0, "after_load_use");
    step(0, 1, 0, 0, 0, 0, 0, 0, 0, Def, 0, 1, 0, 0, "x0_guard");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 1, 0, 0, "after_x0");
    step(0, 1, 7, 3, 7, 0, 0, 0, 0, Lu,  0, 1, 0, 0, "load_use_rs2");
    step(0, 0, 7, 3, 7, 0, 0, 0, 0, Def, 0, 2, 0, 0, "no_memread");
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, Def, 0, 2, 0, 0, "branch_not_taken");
    step(0, 1, 5, 5, 0, 1, 1, 0, 0, Brt, 0, 2, 0, 0, "branch_over_load_use");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 2, 1, 0, "after_branch");
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, Def, 0, 2, 1, 0, "ready_in_run");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, Def, 0, 2, 1, 0, "req_ready_same_cycle");

    // Memory wait with a pending branch and load-use; mem_req drops mid-wait.
    step(0, 1, 5, 5, 0, 1, 1, 1, 0, Frz, 0, 2, 1, 0, "mw_cycle1");
    step(0, 1, 5, 5, 0, 1, 1, 1, 0, Frz, 1, 3, 1, 0, "mw_cycle2");
    step(0, 1, 5, 5, 0, 1, 1, 0, 0, Frz, 1, 4, 1, 0, "mw_cycle3_req_low");
    step(0, 1, 5, 5, 0, 1, 1, 1, 1, Brt, 1, 5, 1, 0, "mw_release_branch");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 5, 2, 0, "after_mw");

    // Release into a load-use.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 0, 5, 2, 0, "mw2_cycle1");
    step(0, 1, 5, 5, 0, 0, 0, 0, 1, Lu,  1, 6, 2, 0, "mw2_release_load_use");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 7, 2, 0, "after_mw2");

    // Timeout with MEM_TIMEOUT=4: the flag sets at the end of the fifth wait cycle.
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 0, 7,  2, 0, "tmo_c1");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 1, 8,  2, 0, "tmo_c2");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 1, 9,  2, 0, "tmo_c3");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 1, 10, 2, 0, "tmo_c4");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 1, 11, 2, 0, "tmo_c5");
    step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, 1, 12, 2, 1, "tmo_c6_err_set");
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, Def, 1, 13, 2, 1, "tmo_release");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 13, 2, 1, "err_sticky1");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 13, 2, 1, "err_sticky2");
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 13, 2, 1, "rst_cycle");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0,  0, 0, "after_rst");

    // Reset in the middle of a wait once stall_cnt reaches 7.
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 0, Frz, (i > 0), i, 0, (i >= 5), "wait_before_rst");
    end
    step(1, 0, 0, 0, 0, 0, 0, 1, 0, Def, 1, 7, 0, 1, "rst_mid_wait");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0, 0, 0, "after_rst_mid_wait");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0, 0, 0, "idle_after_rst");

    // stall_cnt wraps modulo 2^CntW.
    for (int i = 0; i < 256; i++) begin
      step(0, 1, 9, 0, 9, 0, 0, 0, 0, Lu, 0, i, 0, 0, "stall_cnt_count");
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, Def, 0, 0, 0, 0, "stall_cnt_wrap");

    // Let the monitor drain the last expectation.
    for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
      @(posedge clk);
    end
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
